// File: rtl/event_window_ctrl.sv
// -----------------------------------------------------------------------------
// event_window_ctrl
//
// Consumer-side controller for the event window buffer. Takes one event at a
// time from an upstream valid/ready stream, writes it into the buffer, waits
// for the write to complete, requests the 3x3 window centred on the same
// address, and offers the captured window to a downstream valid/ready sink.
//
// Handshake rule (both streams): a transfer happens on a rising clk edge where
// valid and ready are both high. Once valid is raised, valid and its payload
// stay stable until that transfer edge.
//
// Optional feature (macro EVT_CNT_EN): adds evt_count (OUT handshakes, wraps)
// and drop_count (timeout aborts, saturates at 255). Undefined by default.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   s_event_*           upstream event stream (addr = {row[15:8], col[7:0]})
//   buf_event_*         one-cycle write pulse + held write address/value
//   buf_write_done      buffer write-complete pulse
//   buf_read_req        one-cycle window read pulse
//   buf_window_addr     window centre address (held latched address)
//   buf_window_value    packed window, [0][0] in MSBs, [2][2] in LSBs
//   buf_window_valid    window valid pulse
//   m_window_*          downstream window stream
//   evt_count           (EVT_CNT_EN) completed output handshakes
//   drop_count          (EVT_CNT_EN) timeout aborts
//   dbg_state           current FSM state encoding
//   err_timeout         sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module event_window_ctrl #(
  parameter int DATA_WIDTH     = 4,
  parameter int WINDOW_SIZE    = 3,
  parameter int TIMEOUT_CYCLES = 512
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       s_event_valid,
  output logic                                       s_event_ready,
  input  logic [15:0]                                s_event_addr,
  input  logic [DATA_WIDTH-1:0]                      s_event_value,
  output logic                                       buf_event_valid,
  output logic [15:0]                                buf_event_addr,
  output logic [DATA_WIDTH-1:0]                      buf_event_value,
  input  logic                                       buf_write_done,
  output logic                                       buf_read_req,
  output logic [15:0]                                buf_window_addr,
  input  logic [WINDOW_SIZE*WINDOW_SIZE*DATA_WIDTH-1:0] buf_window_value,
  input  logic                                       buf_window_valid,
  output logic                                       m_window_valid,
  input  logic                                       m_window_ready,
  output logic [WINDOW_SIZE*WINDOW_SIZE*DATA_WIDTH-1:0] m_window_value,
  output logic [15:0]                                m_window_addr,
`ifdef EVT_CNT_EN
  output logic [15:0]                                evt_count,
  output logic [7:0]                                 drop_count,
`endif
  output logic [2:0]                                 dbg_state,
  output logic                                       err_timeout
);

  localparam int WIN_W = WINDOW_SIZE * WINDOW_SIZE * DATA_WIDTH;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    OUT     = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [15:0]             addr_q;
  logic [DATA_WIDTH-1:0]   value_q;
  logic [CNT_W-1:0]        wait_cnt_q;
  logic [WIN_W-1:0]        win_q;
  logic [15:0]             win_addr_q;
  logic                    err_q;
  logic                    timeout_hit;
  logic                    accept;
  logic                    capture;
  logic                    out_done;

  // Next-state logic and pulse outputs decoded from the current state.
  always_comb begin
    state_d         = state_q;
    timeout_hit     = 1'b0;
    accept          = 1'b0;
    capture         = 1'b0;
    out_done        = 1'b0;
    s_event_ready   = 1'b0;
    buf_event_valid = 1'b0;
    buf_read_req    = 1'b0;
    m_window_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        s_event_ready = 1'b1;
        if (s_event_valid) begin
          accept  = 1'b1;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        buf_event_valid = 1'b1;
        state_d         = WR_WAIT;
      end
      WR_WAIT: begin
        if (buf_write_done) begin
          state_d = RD_REQ;
        end else if (wait_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      RD_REQ: begin
        buf_read_req = 1'b1;
        state_d      = RD_WAIT;
      end
      RD_WAIT: begin
        if (buf_window_valid) begin
          capture = 1'b1;
          state_d = OUT;
        end else if (wait_cnt_q == TO_LAST) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      OUT: begin
        m_window_valid = 1'b1;
        if (m_window_ready) begin
          out_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      value_q    <= '0;
      wait_cnt_q <= '0;
      win_q      <= '0;
      win_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= s_event_addr;
        value_q <= s_event_value;
      end
      // Counter restarts in each request state so each wait gets a full budget.
      if (state_q == WR_REQ || state_q == RD_REQ) begin
        wait_cnt_q <= '0;
      end else if (state_q == WR_WAIT || state_q == RD_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (capture) begin
        win_q      <= buf_window_value;
        win_addr_q <= addr_q;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef EVT_CNT_EN
  logic [15:0] evt_cnt_q;
  logic [7:0]  drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (out_done) begin
        evt_cnt_q <= evt_cnt_q + 16'd1;
      end
      if (timeout_hit && drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign evt_count  = evt_cnt_q;
  assign drop_count = drop_cnt_q;
`endif

  // Data outputs hold the latched event between pulses.
  assign buf_event_addr  = addr_q;
  assign buf_event_value = value_q;
  assign buf_window_addr = addr_q;
  assign m_window_value  = win_q;
  assign m_window_addr   = win_addr_q;
  assign err_timeout     = err_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_event_window_ctrl.sv
// -----------------------------------------------------------------------------
// tb_event_window_ctrl
//
// Directed bench for event_window_ctrl with a small buffer model: write_done
// arrives two cycles after the write pulse plus a configurable row-shift delay,
// and the window arrives one cycle after the read request.
// -----------------------------------------------------------------------------
module tb_event_window_ctrl;

  localparam int DW = 4;
  localparam int WW = 36;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_WAIT = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // DUT signals
  logic          s_event_valid = 1'b0;
  logic          s_event_ready;
  logic [15:0]   s_event_addr  = '0;
  logic [DW-1:0] s_event_value = '0;
  logic          buf_event_valid;
  logic [15:0]   buf_event_addr;
  logic [DW-1:0] buf_event_value;
  logic          buf_write_done;
  logic          buf_read_req;
  logic [15:0]   buf_window_addr;
  logic [WW-1:0] buf_window_value;
  logic          buf_window_valid;
  logic          m_window_valid;
  logic          m_window_ready = 1'b0;
  logic [WW-1:0] m_window_value;
  logic [15:0]   m_window_addr;
  logic [2:0]    dbg_state;
  logic          err_timeout;
`ifdef EVT_CNT_EN
  logic [15:0]   evt_count;
  logic [7:0]    drop_count;
`endif

  event_window_ctrl #(.DATA_WIDTH(DW), .WINDOW_SIZE(3), .TIMEOUT_CYCLES(512)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_event_valid    (s_event_valid),
    .s_event_ready    (s_event_ready),
    .s_event_addr     (s_event_addr),
    .s_event_value    (s_event_value),
    .buf_event_valid  (buf_event_valid),
    .buf_event_addr   (buf_event_addr),
    .buf_event_value  (buf_event_value),
    .buf_write_done   (buf_write_done),
    .buf_read_req     (buf_read_req),
    .buf_window_addr  (buf_window_addr),
    .buf_window_value (buf_window_value),
    .buf_window_valid (buf_window_valid),
    .m_window_valid   (m_window_valid),
    .m_window_ready   (m_window_ready),
    .m_window_value   (m_window_value),
    .m_window_addr    (m_window_addr),
`ifdef EVT_CNT_EN
    .evt_count        (evt_count),
    .drop_count       (drop_count),
`endif
    .dbg_state        (dbg_state),
    .err_timeout      (err_timeout)
  );

  // buffer model
  int            shift_cfg = 0;
  bit            block_wd  = 1'b0;
  bit            block_wv  = 1'b0;
  logic          inj_wv    = 1'b0;
  logic [WW-1:0] win_pattern = '0;
  int            wd_cnt;
  logic          rd_pend;

  always @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt  <= 0;
      rd_pend <= 1'b0;
    end else begin
      if (buf_event_valid) wd_cnt <= 2 + shift_cfg;
      else if (wd_cnt > 0) wd_cnt <= wd_cnt - 1;
      rd_pend <= buf_read_req;
    end
  end

  assign buf_write_done   = (wd_cnt == 1) && !block_wd;
  assign buf_window_valid = (rd_pend && !block_wv) || inj_wv;
  assign buf_window_value = win_pattern;

  // scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Bounded wait for m_window_valid; called at posedge+1, returns at a negedge.
  task automatic wait_mvalid(input string tag);
    int e;
    e = 0;
    while (e < 700) begin
      @(negedge clk);
      if (m_window_valid) break;
      @(posedge clk); #1;
      e++;
    end
    if (e >= 700) begin
      failures++;
      checks++;
      $display("FAIL %s_wait actual=timeout required=m_window_valid", tag);
    end
  endtask

  // Called at a negedge with m_window_valid high; returns at posedge+1 in IDLE.
  task automatic handshake();
    m_window_ready = 1'b1;
    @(posedge clk); #1;
    m_window_ready = 1'b0;
    @(negedge clk);
    chk("hs_mvalid_low", m_window_valid, 1'b0);
    chk("hs_ready_back", s_event_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  // Full transaction with per-edge latency tracking (edge 0 = accept edge).
  task automatic run_event(input logic [15:0] addr, input logic [DW-1:0] val,
                           input int shift, input logic [WW-1:0] pattern,
                           input int exp_rd, input int exp_mv);
    int e, wr_n, rd_n, rd_e, mv_e;
`ifdef EVT_CNT_EN
    logic [15:0] evt_before;
    evt_before = evt_count;
`endif
    shift_cfg     = shift;
    win_pattern   = pattern;
    s_event_addr  = addr;
    s_event_value = val;
    s_event_valid = 1'b1;
    @(negedge clk);
    chk("pre_accept_ready", s_event_ready, 1'b1);
    @(posedge clk); #1;
    s_event_valid = 1'b0;
    s_event_addr  = ~addr;
    s_event_value = ~val;
    e = 0; wr_n = 0; rd_n = 0; rd_e = -1; mv_e = -1;
    while (e < 700) begin
      @(negedge clk);
      if (buf_event_valid) begin
        wr_n++;
        chk("wr_edge", e, 0);
        chk("wr_addr", buf_event_addr, addr);
        chk("wr_value", buf_event_value, val);
      end
      if (buf_read_req) begin
        rd_n++;
        rd_e = e;
        chk("rd_addr", buf_window_addr, addr);
      end
      if (m_window_valid) begin
        mv_e = e;
        break;
      end
      @(posedge clk); #1;
      e++;
    end
    chk("wr_pulses", wr_n, 1);
    chk("rd_pulses", rd_n, 1);
    chk("rd_edge", rd_e, exp_rd);
    chk("mv_edge", mv_e, exp_mv);
    chk("m_value", m_window_value, pattern);
    chk("m_addr", m_window_addr, addr);
    chk("busy_ready_low", s_event_ready, 1'b0);
    handshake();
`ifdef EVT_CNT_EN
    chk("evt_count_inc", evt_count, evt_before + 16'd1);
`endif
  endtask

  typedef struct {
    logic [15:0]   addr;
    logic [DW-1:0] val;
    int            shift;
    logic [WW-1:0] pattern;
    int            exp_rd;
    int            exp_mv;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{16'h0005, 4'h7, 0, 36'h000070000, 3, 5};
    vecs[1] = '{16'h0505, 4'hA, 3, 36'h12345678A, 6, 8};
    vecs[2] = '{16'hFFFF, 4'hF, 0, 36'hFFFFFFFFF, 3, 5};
    vecs[3] = '{16'h8001, 4'h0, 1, 36'h800000001, 4, 6};

    // reset held 3 cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", s_event_ready, 1'b1);
    chk("rst_buf_valid", buf_event_valid, 1'b0);
    chk("rst_read_req", buf_read_req, 1'b0);
    chk("rst_mvalid", m_window_valid, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_buf_addr", buf_event_addr, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven transactions
    for (int i = 0; i < 4; i++) begin
      run_event(vecs[i].addr, vecs[i].val, vecs[i].shift, vecs[i].pattern,
                vecs[i].exp_rd, vecs[i].exp_mv);
    end

    // downstream backpressure with a second event waiting
    shift_cfg     = 0;
    win_pattern   = 36'hABCDEF012;
    s_event_addr  = 16'h0102;
    s_event_value = 4'h3;
    s_event_valid = 1'b1;
    @(posedge clk); #1;
    s_event_valid = 1'b0;
    wait_mvalid("bp");
    s_event_addr  = 16'h0203;
    s_event_value = 4'h9;
    s_event_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_mvalid_held", m_window_valid, 1'b1);
      chk("bp_value_held", m_window_value, 36'hABCDEF012);
      chk("bp_addr_held", m_window_addr, 16'h0102);
      chk("bp_ready_low", s_event_ready, 1'b0);
      chk("bp_no_write", buf_event_valid, 1'b0);
    end
    m_window_ready = 1'b1;
    @(posedge clk); #1;
    m_window_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", s_event_ready, 1'b1);
    chk("bp_release_mvalid", m_window_valid, 1'b0);
    @(posedge clk); #1;
    s_event_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_write", buf_event_valid, 1'b1);
    chk("bp_second_addr", buf_event_addr, 16'h0203);
    chk("bp_second_value", buf_event_value, 4'h9);
    @(posedge clk); #1;
    wait_mvalid("bp2");
    chk("bp2_addr", m_window_addr, 16'h0203);
    handshake();

    // write timeout: write_done never arrives
    block_wd      = 1'b1;
    s_event_addr  = 16'h0300;
    s_event_value = 4'h5;
    s_event_valid = 1'b1;
    @(posedge clk); #1;
    s_event_valid = 1'b0;
    begin
      int rd_n;
      rd_n = 0;
      for (int e = 0; e <= 513; e++) begin
        @(negedge clk);
        if (buf_read_req) rd_n++;
        if (e == 512) begin
          chk("to_err_before", err_timeout, 1'b0);
          chk("to_busy_before", s_event_ready, 1'b0);
        end
        if (e == 513) begin
          chk("to_err_set", err_timeout, 1'b1);
          chk("to_idle_ready", s_event_ready, 1'b1);
          chk("to_idle_state", dbg_state, ST_IDLE);
        end
        if (e < 513) begin
          @(posedge clk); #1;
        end
      end
      chk("to_no_read", rd_n, 0);
    end
`ifdef EVT_CNT_EN
    chk("to_drop_count", drop_count, 8'd1);
`endif
    @(posedge clk); #1;
    block_wd = 1'b0;

    // sticky error survives a normal transaction
    run_event(vecs[0].addr, vecs[0].val, vecs[0].shift, vecs[0].pattern,
              vecs[0].exp_rd, vecs[0].exp_mv);
    chk("err_sticky", err_timeout, 1'b1);

    // reset while in RD_WAIT, then a late window pulse
    block_wv      = 1'b1;
    shift_cfg     = 0;
    s_event_addr  = 16'h0A0B;
    s_event_value = 4'h6;
    s_event_valid = 1'b1;
    @(posedge clk); #1;
    s_event_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("mid_in_rd_wait", dbg_state, ST_RD_WAIT);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_state", dbg_state, ST_IDLE);
    chk("mid_rst_mvalid", m_window_valid, 1'b0);
    chk("mid_rst_ready", s_event_ready, 1'b1);
    chk("mid_rst_err", err_timeout, 1'b0);
    chk("mid_rst_addr", buf_event_addr, 16'h0000);
    block_wv    = 1'b0;
    win_pattern = 36'h111111111;
    inj_wv      = 1'b1;
    @(posedge clk); #1;
    inj_wv = 1'b0;
    @(negedge clk);
    chk("late_wv_mvalid", m_window_valid, 1'b0);
    chk("late_wv_value", m_window_value, 36'h0);
    chk("late_wv_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;

    // recovery after reset
    run_event(vecs[2].addr, vecs[2].val, vecs[2].shift, vecs[2].pattern,
              vecs[2].exp_rd, vecs[2].exp_mv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
